// File: rtl/key_note_select.sv
// key_note_select: synchronises and debounces eight piano keys (C4..C5),
// applies last-pressed monophonic priority and drives the tone generator's
// half-period count, gate and a note_change pulse.
// Optional build macro OCTAVE_SHIFT_EN: when defined, octave_dn (synchronised)
// doubles half_period to play one octave lower; when undefined octave_dn is ignored.
module key_note_select #(
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter int WIDTH_COUNTER   = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [7:0]               keys,
   input  logic                     octave_dn,
   output logic [WIDTH_COUNTER-1:0] half_period,
   output logic                     gate,
   output logic [2:0]               note_idx,
   output logic                     note_change
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] TICK_LAST = CW'(DEBOUNCE_CYCLES - 1);

   typedef enum logic {IDLE = 1'b0, PLAY = 1'b1} state_t;

   // Half-period toggle counts for a 10 MHz clock, indexed by key bit.
   function automatic logic [15:0] note_period(input logic [2:0] idx);
      logic [15:0] p;
      case (idx)
         3'd0:    p = 16'd19111;
         3'd1:    p = 16'd17026;
         3'd2:    p = 16'd15169;
         3'd3:    p = 16'd14317;
         3'd4:    p = 16'd12755;
         3'd5:    p = 16'd11364;
         3'd6:    p = 16'd10124;
         default: p = 16'd9556;
      endcase
      return p;
   endfunction

   // Highest set bit of an 8-bit vector (0 when the vector is empty).
   function automatic logic [2:0] top_bit(input logic [7:0] v);
      logic [2:0] idx;
      idx = 3'd0;
      for (int i = 0; i < 8; i++) begin
         if (v[i]) idx = 3'(i);
      end
      return idx;
   endfunction

   logic [7:0]    sync1, sync2;
   logic [7:0]    hist0, hist1;
   logic [7:0]    deb, deb_prev;
   logic [7:0]    press;
   logic [7:0]    agree;
   logic [CW-1:0] presc;
   logic          tick;
   logic          oct_active;
   logic          latched;

   state_t        state, next_state;
   logic [2:0]    next_idx;
   logic          next_change;
   logic [15:0]   base_period;
   logic [15:0]   shifted_period;

   // Two-flop synchroniser for the raw key levels.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= keys;
         sync2 <= sync1;
      end
   end

`ifdef OCTAVE_SHIFT_EN
   logic oct_s1, oct_s2;

   // Two-flop synchroniser for the octave-down request.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         oct_s1 <= 1'b0;
         oct_s2 <= 1'b0;
      end else begin
         oct_s1 <= octave_dn;
         oct_s2 <= oct_s1;
      end
   end

   assign oct_active = oct_s2;
`else
   // Octave request has no effect in this build.
   assign oct_active = octave_dn & 1'b0;
`endif

   // Debounce sample prescaler: tick is high on the last count before wrap.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         presc <= '0;
      end else if (tick) begin
         presc <= '0;
      end else begin
         presc <= presc + 1'b1;
      end
   end

   assign tick  = (presc == TICK_LAST);

   // A key's debounced level follows the synced level only when the current
   // sample agrees with both stored samples (three agreeing ticks).
   assign agree = ~(sync2 ^ hist0) & ~(sync2 ^ hist1);

   // Sample history and debounced vector, advanced on each tick.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         hist0 <= '0;
         hist1 <= '0;
         deb   <= '0;
      end else if (tick) begin
         hist0 <= sync2;
         hist1 <= hist0;
         deb   <= (agree & sync2) | (~agree & deb);
      end
   end

   // Previous debounced vector for press-edge detection, updated every clock.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         deb_prev <= '0;
      end else begin
         deb_prev <= deb;
      end
   end

   assign press = deb & ~deb_prev;

   // Next-state and note selection: newest press wins, otherwise fall back to
   // the highest still-held key when the sounding key is released.
   always_comb begin
      next_state  = state;
      next_idx    = note_idx;
      next_change = 1'b0;
      case (state)
         IDLE: begin
            if (deb != 8'h00) begin
               next_idx    = top_bit(deb);
               next_state  = PLAY;
               next_change = 1'b1;
            end
         end
         PLAY: begin
            if (press != 8'h00) begin
               next_idx    = top_bit(press);
               next_change = 1'b1;
            end else if (!deb[note_idx] && (deb != 8'h00)) begin
               next_idx    = top_bit(deb);
               next_change = 1'b1;
            end else if (deb == 8'h00) begin
               next_state  = IDLE;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   assign base_period    = note_period(next_idx);
   assign shifted_period = oct_active ? {base_period[14:0], 1'b0} : base_period;

   // Registered FSM state and outputs; half_period tracks the latched note
   // (and octave) from the first latch onward and is never zeroed in IDLE.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= IDLE;
         note_idx    <= 3'd0;
         gate        <= 1'b0;
         note_change <= 1'b0;
         latched     <= 1'b0;
         half_period <= '0;
      end else begin
         state       <= next_state;
         note_idx    <= next_idx;
         gate        <= (next_state == PLAY);
         note_change <= next_change;
         latched     <= latched | next_change;
         if (latched || next_change) begin
            half_period <= WIDTH_COUNTER'(shifted_period);
         end
      end
   end

endmodule

// File: tb/tb_key_note_select.sv
// Bench for key_note_select: random key patterns held long enough to settle,
// an event-level reference model of note priority, and a pulse monitor that
// pops expected {note_idx, half_period} pairs on every note_change.
module tb_key_note_select;

   localparam int DEB  = 4;
   localparam int W    = 16;
   localparam int HOLD = 24;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [7:0]   keys = 8'h00;
   logic         octave_dn = 1'b0;
   logic [W-1:0] half_period;
   logic         gate;
   logic [2:0]   note_idx;
   logic         note_change;

   key_note_select #(.DEBOUNCE_CYCLES(DEB), .WIDTH_COUNTER(W)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .keys        (keys),
      .octave_dn   (octave_dn),
      .half_period (half_period),
      .gate        (gate),
      .note_idx    (note_idx),
      .note_change (note_change)
   );

   // Clock
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int pulse_cnt = 0;
   int pulse_cyc = 0;

   logic [W+2:0] exp_q[$];

   // Reference model state at the level of settled key patterns.
   logic [7:0] m_deb;
   logic       m_play;
   logic [2:0] m_idx;
   logic       m_latched;

   int tbl[8] = '{19111, 17026, 15169, 14317, 12755, 11364, 10124, 9556};

   always @(posedge clk) cyc <= cyc + 1;

   function automatic int hp_of(input logic [2:0] idx, input logic oct);
      int p;
      p = tbl[idx];
`ifdef OCTAVE_SHIFT_EN
      if (oct) p = p * 2;
`else
      if (oct) p = p;
`endif
      return p;
   endfunction

   function automatic logic [2:0] msb(input logic [7:0] v);
      for (int i = 7; i >= 0; i--) begin
         if (v[i]) return 3'(i);
      end
      return 3'd0;
   endfunction

   task automatic check(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, req);
      end
   endtask

   // Monitor: every note_change pulse must match the oldest expected note.
   always @(negedge clk) begin
      if (note_change) begin
         pulse_cnt++;
         pulse_cyc = cyc;
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_pulse: note_idx=%0d half_period=%0d expected no pulse",
                     note_idx, half_period);
         end else begin
            logic [W+2:0] e;
            e = exp_q.pop_front();
            if ({note_idx, half_period} != e || gate !== 1'b1) begin
               errors++;
               $display("FAIL pulse_note: got idx=%0d hp=%0d gate=%0d expected idx=%0d hp=%0d gate=1",
                        note_idx, half_period, gate, e[W+2:W], e[W-1:0]);
            end
         end
      end
   end

   task automatic model_reset();
      m_deb = 8'h00;
      m_play = 1'b0;
      m_idx = 3'd0;
      m_latched = 1'b0;
      exp_q.delete();
   endtask

   task automatic check_outputs(input string name, input logic oct);
      check({name, "_gate"}, int'(gate), int'(m_play));
      check({name, "_idx"}, int'(note_idx), int'(m_idx));
      check({name, "_hp"}, int'(half_period), m_latched ? hp_of(m_idx, oct) : 0);
   endtask

   // Drive a key pattern, predict its note event, hold, then check.
   task automatic apply_segment(input logic [7:0] n, input logic oct, input bit chk_latency);
      logic       ev;
      logic [2:0] ni;
      logic [7:0] pr;
      int         start_pulses;
      int         start_cyc;
      ev = 1'b0;
      ni = m_idx;
      if (!m_play) begin
         if (n != 8'h00) begin
            ev = 1'b1; ni = msb(n); m_play = 1'b1;
         end
      end else begin
         pr = n & ~m_deb;
         if (pr != 8'h00) begin
            ev = 1'b1; ni = msb(pr);
         end else if (!n[m_idx] && n != 8'h00) begin
            ev = 1'b1; ni = msb(n);
         end else if (n == 8'h00) begin
            m_play = 1'b0;
         end
      end
      if (ev) begin
         m_idx = ni;
         m_latched = 1'b1;
         exp_q.push_back({ni, W'(hp_of(ni, oct))});
      end
      m_deb = n;
      @(posedge clk);
      #1;
      keys = n;
      octave_dn = oct;
      start_pulses = pulse_cnt;
      start_cyc = cyc;
      repeat (HOLD) @(posedge clk);
      #1;
      check("pulse_count", pulse_cnt - start_pulses, ev ? 1 : 0);
      check("missed_pulse", exp_q.size(), 0);
      exp_q.delete();
      check_outputs("hold", oct);
      if (chk_latency) begin
         checks++;
         if (pulse_cyc - start_cyc > 2 + 3 * DEB + 2 || pulse_cnt == start_pulses) begin
            errors++;
            $display("FAIL latency: got %0d clocks required at most %0d",
                     pulse_cyc - start_cyc, 2 + 3 * DEB + 2);
         end
      end
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      model_reset();
      check("rst_gate", int'(gate), 0);
      check("rst_hp", int'(half_period), 0);
      check("rst_idx", int'(note_idx), 0);
      check("rst_change", int'(note_change), 0);
      rst_n = 1'b1;
   endtask

   initial begin
      logic [7:0] n;
      int         start_pulses;
      model_reset();
      do_reset();

      // Idle after reset for 100 clocks.
      repeat (100) @(posedge clk);
      #1;
      check_outputs("idle100", 1'b0);
      check("idle100_change_cnt", pulse_cnt, 0);

      // Directed priority sequence.
      apply_segment(8'h01, 1'b0, 1'b1);
      apply_segment(8'h21, 1'b0, 1'b0);
      apply_segment(8'h01, 1'b0, 1'b0);
      apply_segment(8'h00, 1'b0, 1'b0);
      apply_segment(8'h80, 1'b0, 1'b0);
      apply_segment(8'h00, 1'b0, 1'b0);
      check("release_hp", int'(half_period), 9556);
      check("release_idx", int'(note_idx), 7);

      // Bouncing key never settles.
      start_pulses = pulse_cnt;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         #1;
         if (i % 3 == 0) keys[2] = ~keys[2];
      end
      keys = 8'h00;
      repeat (HOLD) @(posedge clk);
      #1;
      check("bounce_gate", int'(gate), 0);
      check("bounce_pulses", pulse_cnt - start_pulses, 0);

      // Octave request, then dropping it alone.
      apply_segment(8'h20, 1'b1, 1'b0);
      apply_segment(8'h20, 1'b0, 1'b0);
      apply_segment(8'h00, 1'b0, 1'b0);

      // Reset in the middle of a note, key still held afterwards.
      apply_segment(8'h10, 1'b0, 1'b0);
      keys = 8'h10;
      do_reset();
      apply_segment(8'h10, 1'b0, 1'b0);

      // Randomised key patterns.
      for (int s = 0; s < 40; s++) begin
         case ($urandom_range(0, 3))
            0: n = 8'h00;
            1: n = m_deb ^ (8'h01 << $urandom_range(0, 7));
            2: n = 8'($urandom_range(0, 255));
            default: n = m_deb | (8'h01 << $urandom_range(0, 7));
         endcase
         apply_segment(n, 1'($urandom_range(0, 1)), 1'b0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/key_note_select.md
Name: key_note_select

Overview:
- Upstream stage of the tone generator in the simple piano.
- Takes 8 raw piano key inputs (C4..C5) and synchronises and debounces them.
- Applies a last-pressed monophonic note priority.
- Drives the tone generator's half-period count and a gate (note-on) signal.

Parameters:
- DEBOUNCE_CYCLES, 50000, clocks between debounce sample ticks (>=2).
- WIDTH_COUNTER, 16, width of half_period output.

Ports:
- clk  input  1  system clock
- rst_n  input  1  synchronous active-low reset
- keys  input  8  raw key levels, 1 = pressed; bit0 = C4 … bit7 = C5
- octave_dn  input  1  octave-down request (used only with OCTAVE_SHIFT_EN)
- half_period  output  WIDTH_COUNTER  tone_gen toggle count for the current note
- gate  output  1  1 while a note sounds
- note_idx  output  3  index of the current note
- note_change  output  1  one-cycle pulse whenever a note is (re)latched

Behaviour:
- Reset (clk edge with rst_n=0):
  - All registers clear: sync, sample history, debounced vector, prescaler.
  - Outputs: half_period=0, gate=0, note_idx=0, note_change=0.
  - Reset mid-note returns to IDLE immediately; no note_change pulse.
- Synchroniser: 2-FF per key.
- Prescaler: counts 0..DEBOUNCE_CYCLES-1; tick=1 for one clock when count==DEBOUNCE_CYCLES-1, then wraps to 0.
- Debounce, on tick, per key:
  - Shift the sync value into a 2-entry history.
  - deb[i] takes the sync value when it equals both history entries; otherwise deb[i] holds.
  - Net effect: 3 agreeing consecutive ticks are required.
- Edge vector: press = deb & ~deb_prev. deb_prev updates every clock.
- Note table, half-period counts for a 10 MHz clock:
  - C4=19111, D4=17026, E4=15169, F4=14317, G4=12755, A4=11364, B4=10124, C5=9556.
  - Index = key bit.
- FSM, evaluated every clock on the debounced state; outputs registered, 1-clock latency after the deb change:
  - IDLE, gate=0:
    - If deb!=0, latch the highest set bit of deb, go to PLAY, pulse note_change.
  - PLAY, gate=1:
    - If press!=0, latch the highest set bit of press and pulse note_change. This applies even if that bit equals note_idx.
    - Else if deb[note_idx]==0 and deb!=0, latch the highest set bit of deb and pulse note_change.
    - Else if deb==0, go to IDLE. gate=0 next cycle; half_period and note_idx hold their last values.
    - A simultaneous press and release of the current key is handled by the press rule.
- half_period always equals table[note_idx] once a note has been latched. It is not zeroed in IDLE.
- note_change is never asserted in IDLE or in the same cycle as reset.

Optional Feature:
- OCTAVE_SHIFT_EN defined:
  - octave_dn is sampled through a 2-FF synchroniser.
  - While it is high, half_period = table[note_idx] << 1 (one octave lower; max 38222 fits 16 bits).
  - A change of octave_dn alone updates half_period on the next clock and does not pulse note_change.
- OCTAVE_SHIFT_EN undefined:
  - octave_dn is ignored.
  - half_period = table[note_idx] only.

Test Plan:
- Reset with keys=8'h00, then 100 clocks → gate=0, half_period=0, note_change never 1.
- DEBOUNCE_CYCLES=4, keys=8'h01 held → gate=1, note_idx=0, half_period=19111, one note_change pulse, within 2+3*4+2 clocks.
- keys=8'h01 held, then keys=8'h21 → note_idx=5, half_period=11364, one pulse. Release bit5 (keys=8'h01) → note_idx=0, half_period=19111, one pulse.
- Key bounce: bit2 toggles every 3 clocks for 40 clocks, then stays low → gate stays 0, no pulse.
- keys=8'h80 then 8'h00 → gate falls to 0; half_period stays 9556; note_idx stays 7.
- With OCTAVE_SHIFT_EN, keys=8'h20 and octave_dn=1 → half_period=22728, gate=1. Dropping octave_dn → 11364 with no note_change pulse.
